// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one UART_tx among NUM_REQ byte sources.
// Issues trmt with the winner's byte, waits for tx_done, then an optional idle gap.
module uart_tx_arb #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     done,
    output logic                   trmt,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic                   busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [PW-1:0] PTR_RST  = PW'(NUM_REQ - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GAP
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic                 trmt_q, trmt_d;
    logic                 busy_q, busy_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [7:0]           tx_data_q, tx_data_d;

    logic [NUM_REQ-1:0][7:0] data_arr;
    logic [PW-1:0]           win;
    logic                    win_found;

    assign data_arr = req_data;

    // Search starts just after the last grant so the previous owner goes last.
    always_comb begin
        int idx;
        win       = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win       = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        gap_d     = gap_q;
        trmt_d    = 1'b0;
        ack_d     = '0;
        done_d    = '0;
        busy_d    = busy_q;
        tx_data_d = tx_data_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    trmt_d      = 1'b1;
                    ack_d[win]  = 1'b1;
                    tx_data_d   = data_arr[win];
                    owner_d     = win;
                    ptr_d       = win;
                    busy_d      = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (tx_done) begin
                    done_d[owner_q] = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                // Leave on the cycle the count hits zero so spacing is GAP+2.
                if (gap_q <= GW'(1)) begin
                    gap_d   = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= PTR_RST;
            gap_q     <= '0;
            trmt_q    <= 1'b0;
            ack_q     <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            gap_q     <= gap_d;
            trmt_q    <= trmt_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign trmt    = trmt_q;
    assign ack     = ack_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: one instance with a 4-clock gap,
// one with no gap for the back-to-back spacing case.
module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        tx_done;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        busy;

    logic [3:0]  req_b;
    logic [31:0] req_data_b;
    logic        tx_done_b;
    logic [3:0]  ack_b;
    logic [3:0]  done_b;
    logic        trmt_b;
    logic [7:0]  tx_data_b;
    logic        busy_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #10 clk = ~clk;

    uart_tx_arb #(.NUM_REQ(4), .GAP_CYCLES(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .done     (done),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .busy     (busy)
    );

    uart_tx_arb #(.NUM_REQ(4), .GAP_CYCLES(0)) u_dut_nogap (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_b),
        .req_data (req_data_b),
        .ack      (ack_b),
        .done     (done_b),
        .trmt     (trmt_b),
        .tx_data  (tx_data_b),
        .tx_done  (tx_done_b),
        .busy     (busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        tx_done = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic wait_trmt();
        int n;
        n = 0;
        while (!trmt && n < 40) begin
            cyc();
            n++;
        end
        if (!trmt) chk("trmt_timeout", 32'(trmt), 32'd1);
    endtask

    task automatic finish_byte(input string tag, input logic [3:0] exp_done);
        int n;
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        chk(tag, 32'(done), 32'(exp_done));
        n = 0;
        while (busy && n < 20) begin
            cyc();
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int busy_cnt;
        logic busy5;
        logic [3:0] exp_ack;
        logic [3:0] ack_or;
        int trmt_cnt;

        rst_n      = 1'b0;
        req        = '0;
        req_data   = '0;
        tx_done    = 1'b0;
        req_b      = '0;
        req_data_b = '0;
        tx_done_b  = 1'b0;
        cyc();
        cyc();
        chk("rst_trmt", 32'(trmt), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_txdata", 32'(tx_data), 32'd0);
        rst_n = 1'b1;

        // single requester, 'g'
        req_data[15:8] = 8'h67;
        req = 4'b0010;
        cyc();
        chk("t1_trmt", 32'(trmt), 32'd1);
        chk("t1_ack", 32'(ack), 32'h2);
        chk("t1_data", 32'(tx_data), 32'h67);
        chk("t1_busy", 32'(busy), 32'd1);
        req = '0;
        cyc();
        chk("t1_trmt_pulse", 32'(trmt), 32'd0);
        chk("t1_ack_pulse", 32'(ack), 32'd0);
        cyc();
        cyc();
        chk("t1_data_hold", 32'(tx_data), 32'h67);
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        chk("t1_done", 32'(done), 32'h2);
        chk("t1_busy_gap", 32'(busy), 32'd1);
        cyc();
        chk("t1_done_pulse", 32'(done), 32'd0);
        cyc();
        cyc();
        chk("t1_busy_gap_end", 32'(busy), 32'd1);
        cyc();
        chk("t1_idle", 32'(busy), 32'd0);

        // all four requesters, served 0,1,2,3
        do_reset();
        req_data = 32'h44434241;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_trmt();
            chk("t2_ack", 32'(ack), 32'(1 << k));
            chk("t2_byte", 32'(tx_data), 32'(8'h41 + k));
            req = req & ~ack;
            cyc();
            cyc();
            finish_byte("t2_done", 4'(1 << k));
        end
        trmt_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            trmt_cnt += int'(trmt);
        end
        chk("t2_extra", 32'(trmt_cnt), 32'd0);

        // 0 and 2 held continuously alternate
        do_reset();
        req_data = 32'h00320030;
        req = 4'b0101;
        for (int k = 0; k < 8; k++) begin
            exp_ack = (k % 2 == 1) ? 4'b0100 : 4'b0001;
            wait_trmt();
            chk("t3_grant", 32'(ack), 32'(exp_ack));
            cyc();
            finish_byte("t3_done", exp_ack);
        end
        req = '0;

        // gap of 4: next trmt 6 clocks after tx_done
        do_reset();
        req_data = 32'h00005251;
        req = 4'b0011;
        wait_trmt();
        chk("t4_first", 32'(ack), 32'h1);
        req = 4'b0010;
        cyc();
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        n = 1;
        busy_cnt = 0;
        busy5 = 1'b1;
        while (!trmt && n < 40) begin
            if (n >= 1 && n <= 4) busy_cnt += int'(busy);
            if (n == 5) busy5 = busy;
            cyc();
            n++;
        end
        chk("t4_spacing", 32'(n), 32'd6);
        chk("t4_busy_gap", 32'(busy_cnt), 32'd4);
        chk("t4_busy_idle", 32'(busy5), 32'd0);
        chk("t4_second", 32'(ack), 32'h2);
        req = '0;
        cyc();
        finish_byte("t4_done", 4'b0010);

        // no gap: next trmt 2 clocks after tx_done
        req_data_b = 32'h00005453;
        req_b = 4'b0011;
        n = 0;
        while (!trmt_b && n < 40) begin
            cyc();
            n++;
        end
        chk("t4b_first", 32'(ack_b), 32'h1);
        req_b = 4'b0010;
        cyc();
        tx_done_b = 1'b1;
        cyc();
        tx_done_b = 1'b0;
        chk("t4b_done", 32'(done_b), 32'h1);
        chk("t4b_busy", 32'(busy_b), 32'd0);
        n = 1;
        while (!trmt_b && n < 40) begin
            cyc();
            n++;
        end
        chk("t4b_spacing", 32'(n), 32'd2);
        chk("t4b_second", 32'(ack_b), 32'h2);
        chk("t4b_data", 32'(tx_data_b), 32'h54);
        req_b = '0;

        // reset mid-BUSY aborts the byte
        do_reset();
        req_data = 32'h44434241;
        req = 4'b0100;
        wait_trmt();
        chk("t5_grant", 32'(ack), 32'h4);
        req = '0;
        cyc();
        cyc();
        rst_n = 1'b0;
        cyc();
        chk("t5_trmt", 32'(trmt), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ack", 32'(ack), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        chk("t5_no_done", 32'(done), 32'd0);
        req = 4'b1010;
        wait_trmt();
        chk("t5_regrant", 32'(ack), 32'h2);
        req = '0;
        cyc();
        finish_byte("t5_done2", 4'b0010);

        // spurious tx_done in IDLE, req[3] only during GAP
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        chk("t6_spur_done", 32'(done), 32'd0);
        chk("t6_spur_busy", 32'(busy), 32'd0);
        req = 4'b0001;
        wait_trmt();
        chk("t6_grant", 32'(ack), 32'h1);
        req = '0;
        cyc();
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        req = 4'b1000;
        cyc();
        cyc();
        req = '0;
        ack_or = '0;
        trmt_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            ack_or |= ack;
            trmt_cnt += int'(trmt);
        end
        chk("t6_no_ack3", 32'(ack_or), 32'd0);
        chk("t6_no_trmt", 32'(trmt_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
